// File: rtl/prescaled_timer_if.sv
// Control/status bundle for prescaled_timer.
// master drives controls; slave is the timer.
interface prescaled_timer_if #(
  parameter int NUM_BITS      = 16,
  parameter int PRESCALE_BITS = 8
);
  localparam int PW = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;

  logic                clear;
  logic                load;
  logic [NUM_BITS-1:0] load_val;
  logic                en;
  logic                dir;
  logic                one_shot;
  logic [PW-1:0]       prescale;
  logic [NUM_BITS-1:0] rollover_val;
  logic [NUM_BITS-1:0] count;
  logic                rollover_flag;
  logic                done;

  modport master (
    output clear, load, load_val, en, dir,
    output one_shot, prescale, rollover_val,
    input  count, rollover_flag, done
  );

  modport slave (
    input  clear, load, load_val, en, dir,
    input  one_shot, prescale, rollover_val,
    output count, rollover_flag, done
  );
endinterface

// File: rtl/prescaled_timer.sv
// Prescaled up/down timer with runtime period,
// one-shot or free-run, and aligned terminal pulse.
module prescaled_timer #(
  parameter int NUM_BITS      = 16,
  parameter int PRESCALE_BITS = 8
) (
  input logic               clk,
  input logic               n_rst,
  prescaled_timer_if.slave  bus
);
  localparam int PW = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;
  localparam logic [NUM_BITS-1:0] ONE  = 1;
  localparam logic [PW-1:0]       PONE = 1;

  logic [NUM_BITS-1:0] count_q, count_d;
  logic [NUM_BITS-1:0] last;
  logic [PW-1:0]       pre_q, pre_d;
  logic                done_q, done_d;
  logic                flag_q, flag_d;
  logic                tick, step, term;

  // rollover_val of 0 wraps naturally to all ones
  assign last = bus.rollover_val - ONE;

  if (PRESCALE_BITS > 0) begin : g_pre
    assign tick = bus.en & (pre_q >= bus.prescale);
  end else begin : g_nopre
    assign tick = bus.en;
  end

  assign step = tick & ~done_q;
  assign term = bus.dir ? (count_q == '0)
                        : (count_q >= last);

  // next-state: clear > load > step > hold
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = done_q;
    flag_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      pre_d   = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = bus.load_val;
      pre_d   = '0;
      done_d  = 1'b0;
    end else begin
      if (bus.en)
        pre_d = tick ? '0 : pre_q + PONE;
      if (step) begin
        if (term) begin
          flag_d = 1'b1;
          if (bus.one_shot)
            done_d = 1'b1;
          else
            count_d = bus.dir ? last : '0;
        end else if (bus.dir) begin
          count_d = (count_q > last) ? last
                                     : count_q - ONE;
        end else begin
          count_d = count_q + ONE;
        end
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.count         = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_prescaled_timer.sv
// Scoreboard bench for prescaled_timer:
// driver queues expectations, monitor checks them.
module tb_prescaled_timer;
  localparam int N = 4;
  localparam int P = 4;

  typedef struct {
    string      tag;
    logic [N-1:0] c;
    logic       f;
    logic       d;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  prescaled_timer_if #(.NUM_BITS(N), .PRESCALE_BITS(P)) bus ();

  prescaled_timer #(.NUM_BITS(N), .PRESCALE_BITS(P)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] c,
                     input logic f, input logic d);
    checks++;
    if (bus.count !== c || bus.rollover_flag !== f || bus.done !== d) begin
      errors++;
      $display("FAIL %s: got count=%0d flag=%b done=%b, want count=%0d flag=%b done=%b",
               tag, bus.count, bus.rollover_flag, bus.done, c, f, d);
    end
  endtask

  task automatic cyc(input string tag, input logic [N-1:0] c,
                     input logic f, input logic d);
    exp_t e;
    e.tag = tag; e.c = c; e.f = f; e.d = d;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // monitor: outputs are presented every cycle after the edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, e.c, e.f, e.d);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] t2[6];
    logic [N-1:0] t3[12];
    logic [N-1:0] t3b[4];
    t2  = '{1, 2, 0, 1, 2, 0};
    t3  = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    t3b = '{0, 0, 1, 1};

    n_rst = 1'b0;
    bus.clear = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.en = 1'b0;
    bus.dir = 1'b0;
    bus.one_shot = 1'b0;
    bus.prescale = '0;
    bus.rollover_val = 4'd3;
    repeat (2) @(negedge clk);
    chk("reset", 0, 0, 0);
    n_rst = 1'b1;

    // up, period 3, no prescale
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc("t2_up_rv3", t2[i], (i % 3) == 2, 1'b0);

    // period 0 means full 16-state range
    bus.rollover_val = '0;
    for (int i = 1; i < 16; i++)
      cyc("t5_full_count", i[N-1:0], 1'b0, 1'b0);
    cyc("t5_full_wrap", 0, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++)
      cyc("t5_recount", i[N-1:0], 1'b0, 1'b0);

    // async reset mid-count (count=5)
    n_rst = 1'b0;
    #1;
    chk("t1_async_reset", 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // prescale by 3, period 4
    bus.rollover_val = 4'd4;
    bus.prescale = 4'd2;
    for (int i = 0; i < 12; i++)
      cyc("t3_prescale", t3[i], i == 11, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("t3_prescale2", t3b[i], 1'b0, 1'b0);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc("t3_en_low_hold", 1, 1'b0, 1'b0);
    bus.en = 1'b1;
    cyc("t3_resume_pre", 1, 1'b0, 1'b0);
    cyc("t3_resume_step", 2, 1'b0, 1'b0);

    // down one-shot
    bus.prescale = '0;
    bus.dir = 1'b1;
    bus.one_shot = 1'b1;
    bus.load_val = 4'd3;
    bus.load = 1'b1;
    cyc("t4_load3", 3, 1'b0, 1'b0);
    bus.load = 1'b0;
    cyc("t4_down", 2, 1'b0, 1'b0);
    cyc("t4_down", 1, 1'b0, 1'b0);
    cyc("t4_down", 0, 1'b0, 1'b0);
    cyc("t4_done_pulse", 0, 1'b1, 1'b1);
    cyc("t4_done_hold", 0, 1'b0, 1'b1);
    cyc("t4_done_hold", 0, 1'b0, 1'b1);
    bus.load_val = 4'd2;
    bus.load = 1'b1;
    cyc("t4_reload", 2, 1'b0, 1'b0);
    bus.load = 1'b0;
    cyc("t4_resume", 1, 1'b0, 1'b0);
    cyc("t4_resume", 0, 1'b0, 1'b0);
    cyc("t4_done_again", 0, 1'b1, 1'b1);

    // clear+load at terminal, oversized count
    bus.dir = 1'b0;
    bus.one_shot = 1'b0;
    bus.load_val = 4'd3;
    bus.load = 1'b1;
    cyc("t6_load_term", 3, 1'b0, 1'b0);
    bus.clear = 1'b1;
    cyc("t6_clear_wins", 0, 1'b0, 1'b0);
    bus.clear = 1'b0;
    bus.load_val = 4'd9;
    cyc("t6_load9", 9, 1'b0, 1'b0);
    bus.load = 1'b0;
    cyc("t6_up_over_wrap", 0, 1'b1, 1'b0);
    bus.load = 1'b1;
    cyc("t6_load9b", 9, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.dir = 1'b1;
    cyc("t6_down_clamp", 3, 1'b0, 1'b0);
    cyc("t6_down", 2, 1'b0, 1'b0);

    for (int k = 0; k < 10 && sb.size() != 0; k++)
      @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
